// File: rtl/lvds_rx_phase_align.sv
// LVDS receive clock-lane phase aligner: sweeps all 16 rPLL phases, records which
// ones deliver a clean clock-lane word, then centres the PLL on the widest passing window.
module lvds_rx_phase_align #(
   parameter int          SETTLE_CYC  = 64,
   parameter int          SAMPLE_CNT  = 256,
   parameter logic [6:0]  CLK_PATTERN = 7'b1100011,
   parameter int          MIN_WINDOW  = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pll_lock,
   input  logic [6:0]  rx_clk_word,
   input  logic        start,
   output logic [3:0]  psda,
   output logic [3:0]  dutyda,
   output logic [3:0]  fdly,
   output logic        aligned,
   output logic        align_err,
   output logic [4:0]  eye_width,
   output logic [15:0] pass_map
);

   localparam int MAX_CYC = (SETTLE_CYC > SAMPLE_CNT) ? SETTLE_CYC : SAMPLE_CNT;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CNT - 1);

   typedef enum logic [3:0] {
      IDLE         = 4'd0,
      WAIT_LOCK    = 4'd1,
      SET_PHASE    = 4'd2,
      SETTLE       = 4'd3,
      SAMPLE       = 4'd4,
      NEXT         = 4'd5,
      EVAL         = 4'd6,
      APPLY        = 4'd7,
      FINAL_SETTLE = 4'd8,
      DONE         = 4'd9,
      FAIL         = 4'd10
   } state_t;

   state_t         state_r, state_nx_s;
   logic [3:0]     lock_cnt_r, lock_cnt_nx_s;
   logic [CW-1:0]  cnt_r, cnt_nx_s;
   logic [3:0]     index_r, index_nx_s;
   logic           ok_r, ok_nx_s;
   logic [4:0]     scan_r, scan_nx_s;
   logic [4:0]     run_len_r, run_len_nx_s;
   logic [3:0]     run_start_r, run_start_nx_s;
   logic [4:0]     best_len_r, best_len_nx_s;
   logic [3:0]     best_start_r, best_start_nx_s;
   logic [3:0]     center_r, center_nx_s;
   logic [3:0]     psda_r, psda_nx_s;
   logic           aligned_r, aligned_nx_s;
   logic           align_err_r, align_err_nx_s;
   logic [4:0]     eye_width_r, eye_width_nx_s;
   logic [15:0]    pass_map_r, pass_map_nx_s;

   logic           lock_lost_s;
   logic           scan_bit_s;
   logic [4:0]     cur_len_s;
   logic [3:0]     cur_start_s;
   logic           better_s;
   logic [4:0]     fin_len_s;
   logic [3:0]     fin_start_s;
   logic [3:0]     half_s;
   logic           all_ones_s;

   // Circular run tracker: the run length saturates at 16 so the 32-step scan never wraps it.
   assign scan_bit_s  = pass_map_r[scan_r[3:0]];
   assign cur_len_s   = scan_bit_s ? ((run_len_r == 5'd16) ? 5'd16 : run_len_r + 5'd1) : 5'd0;
   assign cur_start_s = (run_len_r == 5'd0) ? scan_r[3:0] : run_start_r;
   assign better_s    = (cur_len_s > best_len_r);
   assign fin_len_s   = better_s ? cur_len_s : best_len_r;
   assign fin_start_s = better_s ? cur_start_s : best_start_r;
   assign half_s      = 4'((fin_len_s - 5'd1) >> 1);
   assign all_ones_s  = (pass_map_r == 16'hFFFF);
   assign lock_lost_s = (state_r != IDLE) && (state_r != WAIT_LOCK) && !pll_lock;

   // Next-state and datapath next values; lock loss overrides everything including start.
   always_comb begin
      state_nx_s      = state_r;
      lock_cnt_nx_s   = lock_cnt_r;
      cnt_nx_s        = cnt_r;
      index_nx_s      = index_r;
      ok_nx_s         = ok_r;
      scan_nx_s       = scan_r;
      run_len_nx_s    = run_len_r;
      run_start_nx_s  = run_start_r;
      best_len_nx_s   = best_len_r;
      best_start_nx_s = best_start_r;
      center_nx_s     = center_r;
      psda_nx_s       = psda_r;
      aligned_nx_s    = aligned_r;
      align_err_nx_s  = align_err_r;
      eye_width_nx_s  = eye_width_r;
      pass_map_nx_s   = pass_map_r;

      if (lock_lost_s) begin
         state_nx_s     = WAIT_LOCK;
         lock_cnt_nx_s  = 4'd0;
         aligned_nx_s   = 1'b0;
         align_err_nx_s = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               state_nx_s = WAIT_LOCK;
            end
            WAIT_LOCK: begin
               index_nx_s     = 4'd0;
               pass_map_nx_s  = 16'h0000;
               eye_width_nx_s = 5'd0;
               cnt_nx_s       = '0;
               aligned_nx_s   = 1'b0;
               align_err_nx_s = 1'b0;
               if (pll_lock) begin
                  if (lock_cnt_r == 4'd15) begin
                     lock_cnt_nx_s = 4'd0;
                     state_nx_s    = SET_PHASE;
                  end else begin
                     lock_cnt_nx_s = lock_cnt_r + 4'd1;
                  end
               end else begin
                  lock_cnt_nx_s = 4'd0;
               end
            end
            SET_PHASE: begin
               psda_nx_s  = index_r;
               cnt_nx_s   = '0;
               ok_nx_s    = 1'b1;
               state_nx_s = SETTLE;
            end
            SETTLE: begin
               if (cnt_r == SETTLE_LAST) begin
                  cnt_nx_s   = '0;
                  state_nx_s = SAMPLE;
               end else begin
                  cnt_nx_s = cnt_r + CW'(1);
               end
            end
            SAMPLE: begin
               ok_nx_s = ok_r & (rx_clk_word == CLK_PATTERN);
               if (cnt_r == SAMPLE_LAST) begin
                  cnt_nx_s   = '0;
                  state_nx_s = NEXT;
               end else begin
                  cnt_nx_s = cnt_r + CW'(1);
               end
            end
            NEXT: begin
               pass_map_nx_s[index_r] = ok_r;
               if (index_r != 4'd15) begin
                  index_nx_s = index_r + 4'd1;
                  state_nx_s = SET_PHASE;
               end else begin
                  scan_nx_s       = 5'd0;
                  run_len_nx_s    = 5'd0;
                  run_start_nx_s  = 4'd0;
                  best_len_nx_s   = 5'd0;
                  best_start_nx_s = 4'd0;
                  state_nx_s      = EVAL;
               end
            end
            EVAL: begin
               run_len_nx_s    = cur_len_s;
               run_start_nx_s  = cur_start_s;
               best_len_nx_s   = fin_len_s;
               best_start_nx_s = fin_start_s;
               scan_nx_s       = scan_r + 5'd1;
               if (scan_r == 5'd31) begin
                  eye_width_nx_s = all_ones_s ? 5'd16 : fin_len_s;
                  center_nx_s    = all_ones_s ? 4'd8 : (fin_start_s + half_s);
                  if (fin_len_s < 5'(MIN_WINDOW)) begin
                     psda_nx_s      = 4'd0;
                     align_err_nx_s = 1'b1;
                     state_nx_s     = FAIL;
                  end else begin
                     state_nx_s = APPLY;
                  end
               end else begin
                  state_nx_s = EVAL;
               end
            end
            APPLY: begin
               psda_nx_s  = center_r;
               cnt_nx_s   = '0;
               state_nx_s = FINAL_SETTLE;
            end
            FINAL_SETTLE: begin
               if (cnt_r == SETTLE_LAST) begin
                  cnt_nx_s     = '0;
                  aligned_nx_s = 1'b1;
                  state_nx_s   = DONE;
               end else begin
                  cnt_nx_s = cnt_r + CW'(1);
               end
            end
            DONE: begin
               if (start) begin
                  aligned_nx_s  = 1'b0;
                  lock_cnt_nx_s = 4'd0;
                  state_nx_s    = WAIT_LOCK;
               end else begin
                  aligned_nx_s = 1'b1;
               end
            end
            FAIL: begin
               psda_nx_s = 4'd0;
               if (start) begin
                  align_err_nx_s = 1'b0;
                  lock_cnt_nx_s  = 4'd0;
                  state_nx_s     = WAIT_LOCK;
               end else begin
                  align_err_nx_s = 1'b1;
               end
            end
            default: begin
               state_nx_s = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers; every output is taken straight from a flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         lock_cnt_r   <= 4'd0;
         cnt_r        <= '0;
         index_r      <= 4'd0;
         ok_r         <= 1'b0;
         scan_r       <= 5'd0;
         run_len_r    <= 5'd0;
         run_start_r  <= 4'd0;
         best_len_r   <= 5'd0;
         best_start_r <= 4'd0;
         center_r     <= 4'd0;
         psda_r       <= 4'd0;
         aligned_r    <= 1'b0;
         align_err_r  <= 1'b0;
         eye_width_r  <= 5'd0;
         pass_map_r   <= 16'h0000;
      end else begin
         state_r      <= state_nx_s;
         lock_cnt_r   <= lock_cnt_nx_s;
         cnt_r        <= cnt_nx_s;
         index_r      <= index_nx_s;
         ok_r         <= ok_nx_s;
         scan_r       <= scan_nx_s;
         run_len_r    <= run_len_nx_s;
         run_start_r  <= run_start_nx_s;
         best_len_r   <= best_len_nx_s;
         best_start_r <= best_start_nx_s;
         center_r     <= center_nx_s;
         psda_r       <= psda_nx_s;
         aligned_r    <= aligned_nx_s;
         align_err_r  <= align_err_nx_s;
         eye_width_r  <= eye_width_nx_s;
         pass_map_r   <= pass_map_nx_s;
      end
   end

   assign psda      = psda_r;
   assign dutyda    = 4'b1000;
   assign fdly      = 4'b0000;
   assign aligned   = aligned_r;
   assign align_err = align_err_r;
   assign eye_width = eye_width_r;
   assign pass_map  = pass_map_r;

endmodule

// File: tb/tb_lvds_rx_phase_align.sv
// Directed bench for lvds_rx_phase_align: a clock-lane model returns the expected word
// only at phases in pass_mask, and each task checks the sweep result against hand values.
module tb_lvds_rx_phase_align;

   localparam int         SETTLE = 4;
   localparam int         SAMPLE = 8;
   localparam logic [6:0] PAT    = 7'b1100011;

   logic        clk = 1'b0;
   logic        reset;
   logic        pll_lock;
   logic        start;
   logic        inject;
   logic [15:0] pass_mask;
   logic [6:0]  rx_clk_word;
   logic [3:0]  psda;
   logic [3:0]  dutyda;
   logic [3:0]  fdly;
   logic        aligned;
   logic        align_err;
   logic [4:0]  eye_width;
   logic [15:0] pass_map;

   int n_cmp = 0;
   int n_bad = 0;

   lvds_rx_phase_align #(
      .SETTLE_CYC (SETTLE),
      .SAMPLE_CNT (SAMPLE),
      .CLK_PATTERN(PAT),
      .MIN_WINDOW (3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pll_lock   (pll_lock),
      .rx_clk_word(rx_clk_word),
      .start      (start),
      .psda       (psda),
      .dutyda     (dutyda),
      .fdly       (fdly),
      .aligned    (aligned),
      .align_err  (align_err),
      .eye_width  (eye_width),
      .pass_map   (pass_map)
   );

   always #5 clk = ~clk;

   assign rx_clk_word = (pass_mask[psda] && !inject) ? PAT : (PAT ^ 7'b0000100);

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         cycles++;
         if (aligned || align_err) return;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL wait_done: no aligned/align_err within %0d cycles", cycles);
   endtask

   task automatic wait_psda(input logic [3:0] v);
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         if (psda == v) return;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL wait_psda: psda never reached %0d", v);
   endtask

   task automatic test_reset();
      int cyc;
      reset = 1'b1; pll_lock = 1'b1; start = 1'b0; inject = 1'b0; pass_mask = 16'h03E0;
      tick(3);
      n_cmp++; if (psda !== 4'd0) begin n_bad++; $display("FAIL rst_psda: got %0d want 0", psda); end
      n_cmp++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL rst_aligned: got %b want 0", aligned); end
      n_cmp++; if (align_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", align_err); end
      n_cmp++; if (eye_width !== 5'd0) begin n_bad++; $display("FAIL rst_eye: got %0d want 0", eye_width); end
      n_cmp++; if (pass_map !== 16'h0000) begin n_bad++; $display("FAIL rst_map: got %h want 0000", pass_map); end
      n_cmp++; if (dutyda !== 4'b1000) begin n_bad++; $display("FAIL rst_dutyda: got %b want 1000", dutyda); end
      n_cmp++; if (fdly !== 4'b0000) begin n_bad++; $display("FAIL rst_fdly: got %b want 0000", fdly); end
      reset = 1'b0;
      wait_done(cyc);
      n_cmp++; if (cyc !== 278) begin n_bad++; $display("FAIL first_latency: got %0d want 278", cyc); end
      n_cmp++; if (pass_map !== 16'h03E0) begin n_bad++; $display("FAIL win5_map: got %h want 03e0", pass_map); end
      n_cmp++; if (eye_width !== 5'd5) begin n_bad++; $display("FAIL win5_eye: got %0d want 5", eye_width); end
      n_cmp++; if (psda !== 4'd7) begin n_bad++; $display("FAIL win5_psda: got %0d want 7", psda); end
      n_cmp++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL win5_aligned: got %b want 1", aligned); end
      n_cmp++; if (align_err !== 1'b0) begin n_bad++; $display("FAIL win5_err: got %b want 0", align_err); end
   endtask

   task automatic test_wrap();
      int cyc;
      pass_mask = 16'hC003;
      pulse_start();
      wait_done(cyc);
      n_cmp++; if (pass_map !== 16'hC003) begin n_bad++; $display("FAIL wrap_map: got %h want c003", pass_map); end
      n_cmp++; if (eye_width !== 5'd4) begin n_bad++; $display("FAIL wrap_eye: got %0d want 4", eye_width); end
      n_cmp++; if (psda !== 4'd15) begin n_bad++; $display("FAIL wrap_psda: got %0d want 15", psda); end
      n_cmp++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL wrap_aligned: got %b want 1", aligned); end
   endtask

   task automatic test_start_in_done();
      int cyc;
      pass_mask = 16'h03E0;
      pulse_start();
      n_cmp++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL restart_drop: aligned got %b want 0", aligned); end
      tick(1);
      n_cmp++; if (pass_map !== 16'h0000) begin n_bad++; $display("FAIL restart_clear: got %h want 0000", pass_map); end
      wait_done(cyc);
      n_cmp++; if (cyc !== 276) begin n_bad++; $display("FAIL restart_latency: got %0d want 276", cyc); end
      n_cmp++; if (pass_map !== 16'h03E0) begin n_bad++; $display("FAIL restart_map: got %h want 03e0", pass_map); end
      n_cmp++; if (psda !== 4'd7) begin n_bad++; $display("FAIL restart_psda: got %0d want 7", psda); end
   endtask

   task automatic test_all_ones_settle_start();
      int cyc;
      pass_mask = 16'hFFFF;
      pulse_start();
      wait_psda(4'd3);
      pulse_start();
      tick(2);
      n_cmp++; if (pass_map !== 16'h0007) begin n_bad++; $display("FAIL settle_start_ignored: map got %h want 0007", pass_map); end
      wait_done(cyc);
      n_cmp++; if (pass_map !== 16'hFFFF) begin n_bad++; $display("FAIL all_map: got %h want ffff", pass_map); end
      n_cmp++; if (eye_width !== 5'd16) begin n_bad++; $display("FAIL all_eye: got %0d want 16", eye_width); end
      n_cmp++; if (psda !== 4'd8) begin n_bad++; $display("FAIL all_psda: got %0d want 8", psda); end
      n_cmp++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL all_aligned: got %b want 1", aligned); end
   endtask

   task automatic test_narrow();
      int cyc;
      pass_mask = 16'h000C;
      pulse_start();
      wait_done(cyc);
      n_cmp++; if (pass_map !== 16'h000C) begin n_bad++; $display("FAIL narrow_map: got %h want 000c", pass_map); end
      n_cmp++; if (eye_width !== 5'd2) begin n_bad++; $display("FAIL narrow_eye: got %0d want 2", eye_width); end
      n_cmp++; if (align_err !== 1'b1) begin n_bad++; $display("FAIL narrow_err: got %b want 1", align_err); end
      n_cmp++; if (psda !== 4'd0) begin n_bad++; $display("FAIL narrow_psda: got %0d want 0", psda); end
      n_cmp++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL narrow_aligned: got %b want 0", aligned); end
   endtask

   task automatic test_inject();
      int cyc;
      pass_mask = 16'h03E0;
      pulse_start();
      wait_psda(4'd7);
      tick(6);
      inject = 1'b1;
      tick(1);
      inject = 1'b0;
      wait_done(cyc);
      n_cmp++; if (pass_map !== 16'h0360) begin n_bad++; $display("FAIL inject_map: got %h want 0360", pass_map); end
      n_cmp++; if (eye_width !== 5'd2) begin n_bad++; $display("FAIL inject_eye: got %0d want 2", eye_width); end
      n_cmp++; if (align_err !== 1'b1) begin n_bad++; $display("FAIL inject_err: got %b want 1", align_err); end
      n_cmp++; if (psda !== 4'd0) begin n_bad++; $display("FAIL inject_psda: got %0d want 0", psda); end
   endtask

   task automatic test_lock_loss();
      int cyc;
      pass_mask = 16'h03E0;
      pulse_start();
      wait_psda(4'd6);
      tick(6);
      n_cmp++; if (pass_map !== 16'h0020) begin n_bad++; $display("FAIL lock_pre_map: got %h want 0020", pass_map); end
      pll_lock = 1'b0;
      tick(3);
      n_cmp++; if (pass_map !== 16'h0000) begin n_bad++; $display("FAIL lock_clear_map: got %h want 0000", pass_map); end
      n_cmp++; if (align_err !== 1'b0) begin n_bad++; $display("FAIL lock_err: got %b want 0", align_err); end
      pll_lock = 1'b1;
      wait_done(cyc);
      n_cmp++; if (cyc !== 277) begin n_bad++; $display("FAIL lock_latency: got %0d want 277", cyc); end
      n_cmp++; if (pass_map !== 16'h03E0) begin n_bad++; $display("FAIL lock_map: got %h want 03e0", pass_map); end
      n_cmp++; if (eye_width !== 5'd5) begin n_bad++; $display("FAIL lock_eye: got %0d want 5", eye_width); end
      n_cmp++; if (psda !== 4'd7) begin n_bad++; $display("FAIL lock_psda: got %0d want 7", psda); end
      n_cmp++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL lock_aligned: got %b want 1", aligned); end
   endtask

   task automatic test_reset_mid_sweep();
      int cyc;
      pass_mask = 16'h03E0;
      pulse_start();
      tick(50);
      reset = 1'b1;
      #1;
      n_cmp++; if (psda !== 4'd0) begin n_bad++; $display("FAIL midrst_psda: got %0d want 0", psda); end
      n_cmp++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL midrst_aligned: got %b want 0", aligned); end
      n_cmp++; if (dutyda !== 4'b1000) begin n_bad++; $display("FAIL midrst_dutyda: got %b want 1000", dutyda); end
      tick(2);
      reset = 1'b0;
      wait_done(cyc);
      n_cmp++; if (cyc !== 278) begin n_bad++; $display("FAIL midrst_latency: got %0d want 278", cyc); end
      n_cmp++; if (pass_map !== 16'h03E0) begin n_bad++; $display("FAIL midrst_map: got %h want 03e0", pass_map); end
      n_cmp++; if (psda !== 4'd7) begin n_bad++; $display("FAIL midrst_psda_final: got %0d want 7", psda); end
      n_cmp++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL midrst_final_aligned: got %b want 1", aligned); end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_start_in_done();
      test_all_ones_settle_start();
      test_narrow();
      test_inject();
      test_lock_loss();
      test_reset_mid_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lvds_rx_phase_align.md
LVDS_RX_PHASE_ALIGN -- requirements
Module: lvds_rx_phase_align

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 64: cycles waited after each psda change before sampling.
REQ-002 SHALL have parameter SAMPLE_CNT, default 256: words checked per phase.
REQ-003 SHALL have parameter CLK_PATTERN, default 7'b1100011: expected deserialized clock-lane word.
REQ-004 SHALL have parameter MIN_WINDOW, default 3: minimum passing phases for success.
REQ-005 SHALL have port clk, input, 1: single clock, the PLL-derived parallel word clock.
REQ-006 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port pll_lock, input, 1: rPLL lock, already synchronous to clk.
REQ-008 SHALL have port rx_clk_word, input, 7: deserialized clock-lane word, one per clk.
REQ-009 SHALL have port start, input, 1: single-cycle pulse that requests re-alignment.
REQ-010 SHALL have port psda, output, 4: rPLL dynamic phase select.
REQ-011 SHALL have port dutyda, output, 4: rPLL duty adjust, constant 4'b1000.
REQ-012 SHALL have port fdly, output, 4: rPLL fine delay, constant 4'b0000.
REQ-013 SHALL have port aligned, output, 1: final phase applied and settled.
REQ-014 SHALL have port align_err, output, 1: sweep found no window of at least MIN_WINDOW.
REQ-015 SHALL have port eye_width, output, 5: length of the best passing window, 0..16.
REQ-016 SHALL have port pass_map, output, 16: bit i set when phase i passed.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_LOCK, SET_PHASE, SETTLE, SAMPLE, NEXT, EVAL, APPLY, FINAL_SETTLE, DONE, FAIL.
REQ-018 IDLE SHALL go to WAIT_LOCK on the cycle after reset deasserts, or on start.
REQ-019 WAIT_LOCK SHALL clear the phase index, pass_map and eye_width.
REQ-020 WAIT_LOCK SHALL go to SET_PHASE when pll_lock has been high for 16 consecutive cycles.
REQ-021 SET_PHASE SHALL drive psda = index for one cycle, then go to SETTLE.
REQ-022 SETTLE SHALL count SETTLE_CYC cycles, then go to SAMPLE.
REQ-023 SAMPLE SHALL compare rx_clk_word to CLK_PATTERN on each of SAMPLE_CNT cycles.
REQ-024 A phase SHALL pass only if all SAMPLE_CNT compares match; there is no early exit.
REQ-025 NEXT SHALL write pass_map[index] in one cycle.
REQ-026 NEXT SHALL go to SET_PHASE with index+1 when index<15, else to EVAL.
REQ-027 EVAL SHALL scan pass_map circularly over 32 steps (bit k mod 16), one per cycle, to find the longest run of ones, capped at 16.
REQ-028 EVAL tie-break SHALL keep the run whose start index is lowest, found first.
REQ-029 If pass_map is all ones, EVAL SHALL give eye_width=16 and center=8.
REQ-030 Otherwise EVAL SHALL give center=(start+(len-1)/2) mod 16, using integer division.
REQ-031 After EVAL, eye_width SHALL be updated.
REQ-032 After EVAL, len<MIN_WINDOW SHALL go to FAIL; otherwise to APPLY.
REQ-033 APPLY SHALL drive psda=center, then go to FINAL_SETTLE.
REQ-034 FINAL_SETTLE SHALL wait SETTLE_CYC cycles, then go to DONE.
REQ-035 DONE SHALL assert aligned.
REQ-036 FAIL SHALL assert align_err and drive psda=0.
REQ-037 psda SHALL hold its value between writes.
REQ-038 pll_lock low in any state other than IDLE SHALL, on the next cycle, clear aligned and align_err and move to WAIT_LOCK, restarting the sweep.
REQ-039 start SHALL be accepted only in DONE or FAIL; it clears aligned and align_err and moves to WAIT_LOCK.
REQ-040 start in any other state SHALL be ignored.
REQ-041 If lock loss and start occur in the same cycle, lock loss SHALL take priority; the outcome is identical.
REQ-042 All outputs SHALL be registered.
REQ-043 Counters SHALL be sized for their parameter and SHALL NOT wrap within a state.

Reset
REQ-044 reset SHALL asynchronously force: state=IDLE, psda=0, aligned=0, align_err=0, eye_width=0, pass_map=0, and all counters to 0.
REQ-045 dutyda and fdly SHALL stay constant through reset.
REQ-046 Reset asserted mid-sweep SHALL abandon the sweep.
REQ-047 After reset deasserts, a full sweep SHALL run without start.

Verification
REQ-048 Model passes phases 5..9 only, lock stable -> pass_map=16'h03E0, eye_width=5, psda=7, aligned=1, align_err=0.
REQ-049 Model passes phases 14,15,0,1 (wrap-around) -> pass_map=16'hC003, eye_width=4, psda=15, aligned=1.
REQ-050 Model passes all phases -> pass_map=16'hFFFF, eye_width=16, psda=8, aligned=1.
REQ-051 Model passes phases 2,3 only -> pass_map=16'h000C, eye_width=2, align_err=1, psda=0, aligned=0.
REQ-052 Drop pll_lock for 3 cycles during SAMPLE of phase 6, then restore -> pass_map cleared, full sweep rerun, same final result as the undisturbed run.
REQ-053 Inject one mismatch word in phase 7 of the 5..9 case -> pass_map=16'h0360, eye_width=2, align_err=1.
REQ-054 Pulse start in DONE -> aligned drops the next cycle and a full sweep repeats.
REQ-055 Pulse start during SETTLE -> ignored.
